// File: rtl/dmem_stq_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_stq_if
// Brief    : Core <-> data-memory load/store port bundle for dmem_stq.
//            master = core side, slave = memory responder side.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_stq_if #(
    parameter int DEPTH = 4
);
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic                     lw_en;
    logic                     sw_en;
    logic [31:0]              rdata;
    logic [$clog2(DEPTH):0]   stq_count;
    logic                     mis_err;

    modport master (
        output addr, wdata, lw_en, sw_en,
        input  rdata, stq_count, mis_err
    );

    modport slave (
        input  addr, wdata, lw_en, sw_en,
        output rdata, stq_count, mis_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_stq.sv
`default_nettype none
// ============================================================================
// Module   : dmem_stq
// Brief    : Data-memory responder with an in-order posted store queue.
//            Stores are queued and drained into a single-port word RAM on
//            idle cycles (or when a store arrives at a full queue). Loads
//            forward from the youngest matching queued store, else read RAM.
//            Load data is registered: 1-cycle latency, holds until next load.
//            Optional macro DMEM_MISALIGN_CHK_EN enables the sticky
//            misaligned-access flag; otherwise mis_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_stq #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_stq_if.slave      bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_q_idx  [DEPTH];
    logic [31:0]       r_q_data [DEPTH];
    logic [31:0]       r_ram    [2**ADDR_W];

    logic [PTR_W-1:0]  r_head;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_rdata;

    logic [ADDR_W-1:0] w_idx;
    logic              w_load;
    logic              w_store;
    logic              w_idle;
    logic              w_drain;
    logic [PTR_W-1:0]  w_tail;
    logic              w_hit;
    logic [31:0]       w_fwd_data;
    logic [PTR_W-1:0]  w_slot;

    assign w_idx   = bus.addr[ADDR_W+1:2];
    // A simultaneous load+store request is handled purely as a store.
    assign w_store = bus.sw_en;
    assign w_load  = bus.lw_en & ~bus.sw_en;
    assign w_idle  = ~bus.lw_en & ~bus.sw_en;
    // RAM is single-port: drain only when the port is otherwise free, or
    // when a store hits a full queue (making room for the push).
    assign w_drain = (r_count != '0) && (w_idle || (w_store && (r_count == C_FULL)));
    // With count == DEPTH the low bits wrap to head; that slot is drained
    // on the same edge, so the overwrite is safe.
    assign w_tail  = r_head + r_count[PTR_W-1:0];

    // Forwarding search: walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_q_idx[w_slot] == w_idx)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_q_data[w_slot];
            end
        end
    end

    // Queue payload storage; occupancy is tracked by head/count only.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_q_idx[w_tail]  <= w_idx;
            r_q_data[w_tail] <= bus.wdata;
        end
    end

    // RAM write port, fed by the queue head; never reset.
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_ram[r_q_idx[r_head]] <= r_q_data[r_head];
        end
    end

    // Queue pointers, occupancy and registered load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_drain);
            if (w_load) begin
                r_rdata <= w_hit ? w_fwd_data : r_ram[w_idx];
            end
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.stq_count = r_count;

`ifdef DMEM_MISALIGN_CHK_EN
    logic r_mis_err;
    logic w_unused_addr;

    // Sticky flag: any request with a non-word-aligned byte address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mis_err <= 1'b0;
        end else if ((bus.lw_en || bus.sw_en) && (bus.addr[1:0] != 2'b00)) begin
            r_mis_err <= 1'b1;
        end
    end

    assign bus.mis_err  = r_mis_err;
    assign w_unused_addr = ^bus.addr[31:ADDR_W+2];
`else
    logic w_unused_addr;

    assign bus.mis_err  = 1'b0;
    assign w_unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

endmodule
`default_nettype wire
